mandelbrot_pixel_scheduler: RTL and testbench

//  Upstream feeder for MandelbrotCalc. Walks a H_RES x V_RES raster in row-major order and derives each pixel's c (Q15.16).

---
 rtl/mandel_pkg.sv | 26 ++
 rtl/mandel_raster_stepper.sv | 77 +++++++
 rtl/mandelbrot_pixel_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_mandelbrot_pixel_scheduler.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mandel_pkg
// Description : Shared widths, coordinate/iteration types and scheduler states
//               for the Mandelbrot pixel scheduler.
// Revision    : 1.0  initial release
// ============================================================================
package mandel_pkg;

    localparam int COORD_W = 32;
    localparam int FRAC_W  = 16;
    localparam int ITER_W  = 16;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic        [ITER_W-1:0]  iter_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GUARD = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/mandel_raster_stepper.sv
`default_nettype none
// ============================================================================
// Module      : mandel_raster_stepper
// Description : Row-major x/y raster counters with incremental Q15.16 c_re/c_im
//               accumulators, driven by load/advance strobes.
// Revision    : 1.0  initial release
// ============================================================================
module mandel_raster_stepper
    import mandel_pkg::*;
#(
    parameter  int H_RES   = 640,
    parameter  int V_RES   = 480,
    parameter  int COORD_W = mandel_pkg::COORD_W,
    localparam int X_W     = (H_RES > 1) ? $clog2(H_RES) : 1,
    localparam int Y_W     = (V_RES > 1) ? $clog2(V_RES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      advance,
    input  logic signed [COORD_W-1:0] x_min,
    input  logic signed [COORD_W-1:0] y_max,
    input  logic signed [COORD_W-1:0] step,
    output logic        [X_W-1:0]     x,
    output logic        [Y_W-1:0]     y,
    output logic signed [COORD_W-1:0] a,
    output logic signed [COORD_W-1:0] b,
    output logic                      last
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    logic        [X_W-1:0]     r_x;
    logic        [Y_W-1:0]     r_y;
    logic signed [COORD_W-1:0] r_a;
    logic signed [COORD_W-1:0] r_b;
    logic signed [COORD_W-1:0] r_x_min;
    logic signed [COORD_W-1:0] r_step;

    // Plain add/sub wraps modulo 2^COORD_W; no saturation is intended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_x_min <= '0;
            r_step  <= '0;
        end else if (load) begin
            r_x     <= '0;
            r_y     <= '0;
            r_a     <= x_min;
            r_b     <= y_max;
            r_x_min <= x_min;
            r_step  <= step;
        end else if (advance) begin
            if (r_x != X_LAST) begin
                r_x <= r_x + 1'b1;
                r_a <= r_a + r_step;
            end else begin
                r_x <= '0;
                r_y <= r_y + 1'b1;
                r_a <= r_x_min;
                r_b <= r_b - r_step;
            end
        end
    end

    assign x    = r_x;
    assign y    = r_y;
    assign a    = r_a;
    assign b    = r_b;
    assign last = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule
`default_nettype wire

// File: rtl/mandelbrot_pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_pixel_scheduler
// Description : Raster feeder for MandelbrotCalc: one pixel in flight, results
//               forwarded on a valid/ready stream. Optional MANDEL_SCHED_PERF_EN
//               adds frame_cycles / iter_total performance counters.
// Revision    : 1.0  initial release
// ============================================================================
module mandelbrot_pixel_scheduler
    import mandel_pkg::*;
#(
    parameter  int H_RES   = 640,
    parameter  int V_RES   = 480,
    parameter  int COORD_W = mandel_pkg::COORD_W,
    parameter  int ITER_W  = mandel_pkg::ITER_W,
    localparam int X_W     = (H_RES > 1) ? $clog2(H_RES) : 1,
    localparam int Y_W     = (V_RES > 1) ? $clog2(V_RES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [COORD_W-1:0] x_min,
    input  logic signed [COORD_W-1:0] y_max,
    input  logic signed [COORD_W-1:0] step,
    output logic signed [COORD_W-1:0] calc_a,
    output logic signed [COORD_W-1:0] calc_b,
    output logic                      calc_en,
    input  logic                      calc_ready,
    input  logic        [ITER_W-1:0]  calc_iter,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic        [X_W-1:0]     pix_x,
    output logic        [Y_W-1:0]     pix_y,
    output logic        [ITER_W-1:0]  pix_iter,
    output logic                      pix_last,
    output logic                      busy,
    output logic                      done
`ifdef MANDEL_SCHED_PERF_EN
    ,
    output logic        [31:0]        frame_cycles,
    output logic        [47:0]        iter_total
`endif
);

    sched_state_e r_state;
    sched_state_e w_next;

    logic             w_load;
    logic             w_advance;
    logic             w_capture;
    logic             w_finish;
    logic             w_slot_free;
    logic [X_W-1:0]   w_x;
    logic [Y_W-1:0]   w_y;
    logic             w_last;

    logic             r_pix_valid;
    logic [X_W-1:0]   r_pix_x;
    logic [Y_W-1:0]   r_pix_y;
    logic [ITER_W-1:0] r_pix_iter;
    logic             r_pix_last;
    logic             r_busy;
    logic             r_done;

    mandel_raster_stepper #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .COORD_W (COORD_W)
    ) u_stepper (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_load),
        .advance (w_advance),
        .x_min   (x_min),
        .y_max   (y_max),
        .step    (step),
        .x       (w_x),
        .y       (w_y),
        .a       (calc_a),
        .b       (calc_b),
        .last    (w_last)
    );

    // The slot may be refilled in the same cycle its current result leaves.
    assign w_slot_free = !r_pix_valid || pix_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_advance = 1'b0;
        w_capture = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = ISSUE;
                end
            end
            ISSUE: w_next = GUARD;
            // calc_ready is deliberately ignored here: it may still reflect the previous pixel.
            GUARD: w_next = WAIT;
            WAIT: begin
                if (calc_ready && w_slot_free) begin
                    w_capture = 1'b1;
                    w_advance = !w_last;
                    w_next    = w_last ? DRAIN : ISSUE;
                end
            end
            DRAIN: begin
                if (r_pix_valid && pix_ready) begin
                    w_finish = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_valid <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_iter  <= '0;
            r_pix_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_capture) begin
                r_pix_valid <= 1'b1;
                r_pix_x     <= w_x;
                r_pix_y     <= w_y;
                r_pix_iter  <= calc_iter;
                r_pix_last  <= w_last;
            end else if (r_pix_valid && pix_ready) begin
                r_pix_valid <= 1'b0;
            end
            if (w_load) begin
                r_busy <= 1'b1;
            end
            if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

`ifdef MANDEL_SCHED_PERF_EN
    logic [31:0] r_frame_cycles;
    logic [47:0] r_iter_total;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cycles <= '0;
            r_iter_total   <= '0;
        end else if (w_load) begin
            r_frame_cycles <= '0;
            r_iter_total   <= '0;
        end else begin
            if (r_busy) begin
                r_frame_cycles <= r_frame_cycles + 32'd1;
            end
            if (w_capture) begin
                r_iter_total <= r_iter_total + 48'(calc_iter);
            end
        end
    end

    assign frame_cycles = r_frame_cycles;
    assign iter_total   = r_iter_total;
`endif

    assign calc_en   = (r_state == ISSUE);
    assign pix_valid = r_pix_valid;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign pix_iter  = r_pix_iter;
    assign pix_last  = r_pix_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mandelbrot_pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mandelbrot_pixel_scheduler
// Description : Self-checking bench with a behavioural MandelbrotCalc model and
//               a result scoreboard; perf checks when MANDEL_SCHED_PERF_EN is set.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mandelbrot_pixel_scheduler;

    localparam int H   = 4;
    localparam int V   = 2;
    localparam int N   = 3;
    localparam int TMO = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] x_min, y_max, step;
    logic [31:0] calc_a, calc_b;
    logic        calc_en;
    logic        calc_ready;
    logic [15:0] calc_iter;
    logic        pix_valid, pix_ready;
    logic [1:0]  pix_x;
    logic [0:0]  pix_y;
    logic [15:0] pix_iter;
    logic        pix_last, busy, done;
`ifdef MANDEL_SCHED_PERF_EN
    logic [31:0] frame_cycles;
    logic [47:0] iter_total;
`endif

    mandelbrot_pixel_scheduler #(
        .H_RES   (H),
        .V_RES   (V),
        .COORD_W (32),
        .ITER_W  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x_min      (x_min),
        .y_max      (y_max),
        .step       (step),
        .calc_a     (calc_a),
        .calc_b     (calc_b),
        .calc_en    (calc_en),
        .calc_ready (calc_ready),
        .calc_iter  (calc_iter),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_iter   (pix_iter),
        .pix_last   (pix_last),
        .busy       (busy),
        .done       (done)
`ifdef MANDEL_SCHED_PERF_EN
        ,
        .frame_cycles (frame_cycles),
        .iter_total   (iter_total)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int it;
        bit last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] a_log[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] f_xmin, f_ymax, f_step;
    int          idx = 0;
    int          en_count = 0;
    int          acc_count = 0;
    int          done_count = 0;
    int          cnt = 0;
    bit          iter_fixed = 1'b1;
    bit          last_hs_prev = 1'b0;

    // Calc model, coordinate checker and result scoreboard, all on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_count++;
                checks++;
                if (!last_hs_prev) begin
                    errors++;
                    $display("FAIL done_timing: done=1 but previous cycle had no last-pixel handshake");
                end
            end
            last_hs_prev = pix_valid && pix_ready && pix_last;

            if (pix_valid && pix_ready) begin
                acc_count++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pix_extra: got x=%0d y=%0d iter=%0d, required no result", pix_x, pix_y, pix_iter);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (int'(pix_x) !== e.x || int'(pix_y) !== e.y || int'(pix_iter) !== e.it || pix_last !== e.last) begin
                        errors++;
                        $display("FAIL pix_data: got x=%0d y=%0d iter=%0d last=%0b, required x=%0d y=%0d iter=%0d last=%0b",
                                 pix_x, pix_y, pix_iter, pix_last, e.x, e.y, e.it, e.last);
                    end
                end
            end

            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) calc_ready = 1'b1;
            end

            if (calc_en) begin
                exp_t        e;
                logic [31:0] ea, eb;
                e.x    = idx % H;
                e.y    = idx / H;
                e.it   = iter_fixed ? 7 : ((idx * 13 + 5) & 16'hffff);
                e.last = (idx == H * V - 1);
                ea     = f_xmin + 32'(e.x) * f_step;
                eb     = f_ymax - 32'(e.y) * f_step;
                checks++;
                if (idx >= H * V) begin
                    errors++;
                    $display("FAIL extra_en: got calc_en for pixel %0d, required at most %0d", idx, H * V);
                end else if (calc_a !== ea || calc_b !== eb) begin
                    errors++;
                    $display("FAIL coord: pixel %0d got a=%h b=%h, required a=%h b=%h", idx, calc_a, calc_b, ea, eb);
                end
                sb.push_back(e);
                a_log.push_back(calc_a);
                calc_iter  = 16'(e.it);
                calc_ready = 1'b0;
                cnt        = N;
                en_count++;
                idx++;
            end
        end else begin
            last_hs_prev = 1'b0;
        end
    end

    task automatic clear_counts();
        sb.delete();
        a_log.delete();
        en_count   = 0;
        acc_count  = 0;
        done_count = 0;
    endtask

    task automatic start_frame(input logic [31:0] xm, input logic [31:0] ym, input logic [31:0] st);
        f_xmin = xm;
        f_ymax = ym;
        f_step = st;
        idx    = 0;
        x_min  = xm;
        y_max  = ym;
        step   = st;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit timeout);
        cycles  = 0;
        timeout = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({calc_en, pix_valid, busy, done, pix_last} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got en/valid/busy/done/last=%b, required 00000", {calc_en, pix_valid, busy, done, pix_last});
        end
        checks++;
        if (calc_a !== 32'h0 || calc_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_coord: got a=%h b=%h, required 0", calc_a, calc_b);
        end
        checks++;
        if (pix_x !== 2'd0 || pix_y !== 1'b0 || pix_iter !== 16'd0) begin
            errors++;
            $display("FAIL reset_pix: got x=%0d y=%0d iter=%0d, required 0", pix_x, pix_y, pix_iter);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_frame();
        int          cyc;
        bit          tmo;
        logic [31:0] row0[4];
        row0 = '{32'hFFFE0000, 32'hFFFE8000, 32'hFFFF0000, 32'hFFFF8000};
        clear_counts();
        iter_fixed = 1'b1;
        pix_ready  = 1'b1;
        start_frame(32'hFFFE0000, 32'h00010000, 32'h00008000);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_busy: got busy=%b, required 1", busy);
        end
        wait_done(cyc, tmo);
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL frame_timeout: got no done in %0d cycles, required done", TMO);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (acc_count !== 8 || sb.size() !== 0 || done_count !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_totals: got acc=%0d left=%0d dones=%0d busy=%b, required 8 0 1 0",
                     acc_count, sb.size(), done_count, busy);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_log.size() <= i || a_log[i] !== row0[i]) begin
                errors++;
                $display("FAIL frame_row0_a%0d: got %h, required %h", i, (a_log.size() > i) ? a_log[i] : 32'hx, row0[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          cyc;
        bit          tmo;
        bit          frozen_ok;
        logic [1:0]  sx;
        logic [0:0]  sy;
        logic [15:0] si;
        clear_counts();
        iter_fixed = 1'b0;
        pix_ready  = 1'b0;
        start_frame(32'h00020000, 32'hFFFF0000, 32'h00001000);
        tmo = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (pix_valid) begin
                tmo = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL bp_first_valid: got pix_valid=0 after 200 cycles, required 1");
        end
        sx = pix_x;
        sy = pix_y;
        si = pix_iter;
        frozen_ok = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (pix_valid !== 1'b1 || pix_x !== sx || pix_y !== sy || pix_iter !== si) frozen_ok = 1'b0;
        end
        checks++;
        if (!frozen_ok) begin
            errors++;
            $display("FAIL bp_frozen: got valid=%b x=%0d y=%0d iter=%0d, required 1 %0d %0d %0d",
                     pix_valid, pix_x, pix_y, pix_iter, sx, sy, si);
        end
        checks++;
        if (en_count !== 2) begin
            errors++;
            $display("FAIL bp_en_count: got %0d calc_en pulses, required 2", en_count);
        end
        pix_ready = 1'b1;
        wait_done(cyc, tmo);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tmo || acc_count !== 8 || sb.size() !== 0 || done_count !== 1) begin
            errors++;
            $display("FAIL bp_totals: got timeout=%b acc=%0d left=%0d dones=%0d, required 0 8 0 1",
                     tmo, acc_count, sb.size(), done_count);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        bit tmo;
        clear_counts();
        iter_fixed = 1'b0;
        pix_ready  = 1'b1;
        start_frame(32'h00100000, 32'hFFF00000, 32'h00004000);
        for (int i = 0; i < 500 && acc_count < 3; i++) begin
            @(posedge clk);
            #1;
        end
        x_min = 32'h12340000;
        y_max = 32'h00000000;
        step  = 32'h00110000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ign_busy: got busy=%b, required 1", busy);
        end
        wait_done(cyc, tmo);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (tmo || acc_count !== 8 || sb.size() !== 0 || done_count !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_totals: got timeout=%b acc=%0d left=%0d dones=%0d busy=%b, required 0 8 0 1 0",
                     tmo, acc_count, sb.size(), done_count, busy);
        end
    endtask

    task automatic test_reset_midframe();
        int cyc;
        bit tmo;
        clear_counts();
        iter_fixed = 1'b0;
        pix_ready  = 1'b1;
        start_frame(32'hFFF80000, 32'h00040000, 32'h00020000);
        for (int i = 0; i < 500 && en_count < 3; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({calc_en, pix_valid, busy, done, pix_last} !== 5'b0 || calc_a !== 32'h0 || calc_b !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got en/valid/busy/done/last=%b a=%h b=%h, required all 0",
                     {calc_en, pix_valid, busy, done, pix_last}, calc_a, calc_b);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_counts();
        @(posedge clk);
        #1;
        start_frame(32'h00030000, 32'hFFFE0000, 32'h00008000);
        wait_done(cyc, tmo);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tmo || acc_count !== 8 || sb.size() !== 0 || done_count !== 1) begin
            errors++;
            $display("FAIL rst_refr: got timeout=%b acc=%0d left=%0d dones=%0d, required 0 8 0 1",
                     tmo, acc_count, sb.size(), done_count);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        bit tmo;
        clear_counts();
        iter_fixed = 1'b1;
        pix_ready  = 1'b1;
        start_frame(32'h7FFF0000, 32'h00000000, 32'h00010000);
        wait_done(cyc, tmo);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tmo || a_log.size() < 2 || a_log[1] !== 32'h80000000) begin
            errors++;
            $display("FAIL wrap_a1: got timeout=%b a1=%h, required 0 80000000",
                     tmo, (a_log.size() > 1) ? a_log[1] : 32'hx);
        end
    endtask

`ifdef MANDEL_SCHED_PERF_EN
    task automatic test_perf();
        int cyc;
        bit tmo;
        clear_counts();
        iter_fixed = 1'b1;
        pix_ready  = 1'b1;
        start_frame(32'hFFFE0000, 32'h00010000, 32'h00008000);
        wait_done(cyc, tmo);
        checks++;
        if (tmo || iter_total !== 48'd56) begin
            errors++;
            $display("FAIL perf_iter: got timeout=%b iter_total=%0d, required 0 56", tmo, iter_total);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (frame_cycles !== 32'(cyc)) begin
            errors++;
            $display("FAIL perf_cycles: got %0d, required %0d", frame_cycles, cyc);
        end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        x_min      = '0;
        y_max      = '0;
        step       = '0;
        calc_ready = 1'b0;
        calc_iter  = '0;
        pix_ready  = 1'b1;
        f_xmin     = '0;
        f_ymax     = '0;
        f_step     = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_frame();
        test_backpressure();
        test_start_ignored();
        test_reset_midframe();
        test_wrap();
`ifdef MANDEL_SCHED_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
